// File: rtl/flash_page_sequencer.sv
// flash_page_sequencer: schedules one page round trip through mem_command.
// The sequence is UART page receive, NAND program, status poll, page read,
// status poll, cache read, then UART page send.
// Build option: define SEQ_POLL_TIMEOUT_EN to bound GET_FEATURE polling to
// MAX_POLLS issues. Without it, polling is unbounded and no poll counter exists.
//
// state  | meaning
// IDLE   | waiting for i_start
// PWR_UP | memory powered, settling for POWER_UP_CYCLES
// URX    | UART fills the FIFO up to one page
// WREN   | WRITE_ENABLE command
// LOAD   | PROG_LOAD1 command, FIFO streams the page to memory
// EXEC   | PROG_EXEC command
// POLL1  | GET_FEATURE after program, P_FAIL checked here
// RDPG   | PAGE_READ command
// POLL2  | GET_FEATURE after page read
// CRD    | CACHE_READ command, FIFO collects the page
// UTX    | UART drains the FIFO
// DONE   | one-cycle completion
// ERR    | sticky error, memory left powered, i_start restarts
module flash_page_sequencer #(
  parameter int         PAGE_BYTES      = 2048,
  parameter int         POWER_UP_CYCLES = 1000,
  parameter int         MAX_POLLS       = 255,
  parameter logic [7:0] FEATURE_ADDR    = 8'hC0
) (
  input  logic        CLK1,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [23:0] i_row_addr,
  input  logic [12:0] i_col_addr,
  output logic [3:0]  o_Command,
  output logic        o_CM_DV,
  output logic [23:0] o_Addr_Data,
  input  logic        i_CM_Ready,
  input  logic [7:0]  i_RX_Feature_Byte,
  input  logic        i_RX_Feature_DV,
  input  logic [12:0] i_fifo_save_count,
  output logic [2:0]  o_fifo_sm,
  output logic        o_Mem_Power,
  output logic        o_SPI_en,
  output logic        o_UART_en,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [7:0]  o_status
);

  // Command and FIFO mode codes; these must track command_vars.v.
  localparam logic [3:0] NO_COMMAND   = 4'h0;
  localparam logic [3:0] WRITE_ENABLE = 4'h1;
  localparam logic [3:0] PROG_LOAD1   = 4'h2;
  localparam logic [3:0] PROG_EXEC    = 4'h3;
  localparam logic [3:0] GET_FEATURE  = 4'h4;
  localparam logic [3:0] PAGE_READ    = 4'h5;
  localparam logic [3:0] CACHE_READ   = 4'h6;

  localparam logic [2:0] FIFO_IDLE         = 3'd0;
  localparam logic [2:0] FIFO_UART_RECEIVE = 3'd1;
  localparam logic [2:0] FIFO_MEM_SEND     = 3'd2;
  localparam logic [2:0] FIFO_MEM_RECEIVE  = 3'd3;
  localparam logic [2:0] FIFO_UART_SEND    = 3'd4;

  localparam logic [12:0]      PAGE_CNT     = 13'(PAGE_BYTES);
  localparam int               PWR_W        = $clog2(POWER_UP_CYCLES + 1);
  localparam logic [PWR_W-1:0] PWR_LOAD     = PWR_W'(POWER_UP_CYCLES - 1);
  localparam logic [23:0]      FEATURE_WORD = {8'h00, FEATURE_ADDR, 8'h00};

  // The poll counter is 8 bits wide, so MAX_POLLS has to fit in it.
  if (MAX_POLLS < 1 || MAX_POLLS > 255) begin : g_max_polls_range
    $error("MAX_POLLS must be in 1..255");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_PWR_UP, S_URX, S_WREN, S_LOAD, S_EXEC, S_POLL1,
    S_RDPG, S_POLL2, S_CRD, S_UTX, S_DONE, S_ERR
  } state_t;

  // Phases of the mem_command handshake inside every command state.
  typedef enum logic [1:0] {HS_ARM, HS_ACK, HS_CMP} hs_t;

  state_t           state_q;
  hs_t              hs_q;
  logic [PWR_W-1:0] pwr_cnt_q;
  logic [3:0]       cmd_q;
  logic             cm_dv_q;
  logic [23:0]      addr_q;
  logic [2:0]       fifo_q;
  logic             mem_pwr_q, spi_en_q, uart_en_q;
  logic             busy_q, done_q, error_q;
  logic [7:0]       status_q;
`ifdef SEQ_POLL_TIMEOUT_EN
  localparam logic [7:0] MAX_POLL_CNT = 8'(MAX_POLLS);
  logic [7:0]       poll_cnt_q;
`endif

  logic [3:0]  cmd_d;
  logic [23:0] addr_d;
  logic [7:0]  feat_d;
  logic        poll_state;

  // Command and packed address for the current command state; the feature
  // byte arriving on the completion cycle takes precedence over the stored one.
  always_comb begin
    cmd_d      = NO_COMMAND;
    addr_d     = 24'h0;
    poll_state = (state_q == S_POLL1) || (state_q == S_POLL2);
    feat_d     = i_RX_Feature_DV ? i_RX_Feature_Byte : status_q;
    case (state_q)
      S_WREN:           cmd_d = WRITE_ENABLE;
      S_LOAD:  begin    cmd_d = PROG_LOAD1;  addr_d = {11'b0, i_col_addr}; end
      S_EXEC:  begin    cmd_d = PROG_EXEC;   addr_d = i_row_addr;          end
      S_POLL1,
      S_POLL2: begin    cmd_d = GET_FEATURE; addr_d = FEATURE_WORD;        end
      S_RDPG:  begin    cmd_d = PAGE_READ;   addr_d = i_row_addr;          end
      S_CRD:   begin    cmd_d = CACHE_READ;  addr_d = {11'b0, i_col_addr}; end
      default: ;
    endcase
  end

  // Sequencer FSM with registered outputs and the per-command handshake.
  always_ff @(posedge CLK1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hs_q      <= HS_ARM;
      pwr_cnt_q <= '0;
      cmd_q     <= NO_COMMAND;
      cm_dv_q   <= 1'b0;
      addr_q    <= 24'h0;
      fifo_q    <= FIFO_IDLE;
      mem_pwr_q <= 1'b0;
      spi_en_q  <= 1'b0;
      uart_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      status_q  <= 8'h00;
`ifdef SEQ_POLL_TIMEOUT_EN
      poll_cnt_q <= 8'h00;
`endif
    end else begin
      cm_dv_q <= 1'b0;
      done_q  <= 1'b0;
      if (poll_state && i_RX_Feature_DV) status_q <= i_RX_Feature_Byte;

      case (state_q)
        S_IDLE, S_ERR: begin
          if (i_start) begin
            state_q   <= S_PWR_UP;
            busy_q    <= 1'b1;
            error_q   <= 1'b0;
            mem_pwr_q <= 1'b1;
            spi_en_q  <= 1'b1;
            uart_en_q <= 1'b0;
            pwr_cnt_q <= PWR_LOAD;
          end
        end
        S_PWR_UP: begin
          if (pwr_cnt_q == '0) begin
            state_q   <= S_URX;
            uart_en_q <= 1'b1;
            fifo_q    <= FIFO_UART_RECEIVE;
          end else begin
            pwr_cnt_q <= pwr_cnt_q - PWR_W'(1);
          end
        end
        S_URX: begin
          if (i_fifo_save_count >= PAGE_CNT) begin
            state_q <= S_WREN;
            fifo_q  <= FIFO_IDLE;
            hs_q    <= HS_ARM;
          end
        end
        S_WREN, S_LOAD, S_EXEC, S_POLL1, S_POLL2, S_RDPG, S_CRD: begin
          case (hs_q)
            HS_ARM: begin
              if (i_CM_Ready) begin
                cmd_q   <= cmd_d;
                addr_q  <= addr_d;
                cm_dv_q <= 1'b1;
                hs_q    <= HS_ACK;
`ifdef SEQ_POLL_TIMEOUT_EN
                if (poll_state && poll_cnt_q != 8'hFF) poll_cnt_q <= poll_cnt_q + 8'd1;
`endif
              end
            end
            HS_ACK: begin
              if (!i_CM_Ready) hs_q <= HS_CMP;
            end
            default: begin
              if (i_CM_Ready) begin
                case (state_q)
                  S_WREN: begin
                    state_q <= S_LOAD;
                    fifo_q  <= FIFO_MEM_SEND;
                    hs_q    <= HS_ARM;
                  end
                  S_LOAD: begin
                    // Hold here until the FIFO has pushed the whole page out.
                    if (i_fifo_save_count == 13'd0) begin
                      state_q <= S_EXEC;
                      fifo_q  <= FIFO_IDLE;
                      hs_q    <= HS_ARM;
                    end
                  end
                  S_EXEC: begin
                    state_q <= S_POLL1;
                    hs_q    <= HS_ARM;
`ifdef SEQ_POLL_TIMEOUT_EN
                    poll_cnt_q <= 8'h00;
`endif
                  end
                  S_RDPG: begin
                    state_q <= S_POLL2;
                    hs_q    <= HS_ARM;
`ifdef SEQ_POLL_TIMEOUT_EN
                    poll_cnt_q <= 8'h00;
`endif
                  end
                  S_POLL1, S_POLL2: begin
                    if (feat_d[0]) begin
`ifdef SEQ_POLL_TIMEOUT_EN
                      if (poll_cnt_q >= MAX_POLL_CNT) begin
                        state_q   <= S_ERR;
                        error_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        spi_en_q  <= 1'b0;
                        uart_en_q <= 1'b0;
                        fifo_q    <= FIFO_IDLE;
                      end else begin
                        hs_q <= HS_ARM;
                      end
`else
                      hs_q <= HS_ARM;
`endif
                    end else if (state_q == S_POLL1 && feat_d[3]) begin
                      state_q   <= S_ERR;
                      error_q   <= 1'b1;
                      busy_q    <= 1'b0;
                      spi_en_q  <= 1'b0;
                      uart_en_q <= 1'b0;
                      fifo_q    <= FIFO_IDLE;
                    end else if (state_q == S_POLL1) begin
                      state_q <= S_RDPG;
                      hs_q    <= HS_ARM;
                    end else begin
                      state_q <= S_CRD;
                      fifo_q  <= FIFO_MEM_RECEIVE;
                      hs_q    <= HS_ARM;
                    end
                  end
                  S_CRD: begin
                    if (i_fifo_save_count >= PAGE_CNT) begin
                      state_q <= S_UTX;
                      fifo_q  <= FIFO_UART_SEND;
                    end
                  end
                  default: ;
                endcase
              end
            end
          endcase
        end
        S_UTX: begin
          if (i_fifo_save_count == 13'd0) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            fifo_q    <= FIFO_IDLE;
            uart_en_q <= 1'b0;
            spi_en_q  <= 1'b0;
            mem_pwr_q <= 1'b0;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_Command   = cmd_q;
  assign o_CM_DV     = cm_dv_q;
  assign o_Addr_Data = addr_q;
  assign o_fifo_sm   = fifo_q;
  assign o_Mem_Power = mem_pwr_q;
  assign o_SPI_en    = spi_en_q;
  assign o_UART_en   = uart_en_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_error     = error_q;
  assign o_status    = status_q;

endmodule

// File: tb/tb_flash_page_sequencer.sv
// Bench for flash_page_sequencer: a mem_command responder and FIFO occupancy
// model run in the background, while one initial block walks through directed
// and randomized page round trips and compares against an expected command list.
module tb_flash_page_sequencer;

  localparam logic [3:0] NO_COMMAND   = 4'h0;
  localparam logic [3:0] WRITE_ENABLE = 4'h1;
  localparam logic [3:0] PROG_LOAD1   = 4'h2;
  localparam logic [3:0] PROG_EXEC    = 4'h3;
  localparam logic [3:0] GET_FEATURE  = 4'h4;
  localparam logic [3:0] PAGE_READ    = 4'h5;
  localparam logic [3:0] CACHE_READ   = 4'h6;
  localparam logic [2:0] FIFO_IDLE         = 3'd0;
  localparam logic [2:0] FIFO_UART_RECEIVE = 3'd1;
  localparam logic [2:0] FIFO_MEM_SEND     = 3'd2;
  localparam logic [2:0] FIFO_MEM_RECEIVE  = 3'd3;
  localparam logic [2:0] FIFO_UART_SEND    = 3'd4;
  localparam logic [23:0] GF_ADDR = 24'h00C000;

  logic        CLK1 = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [23:0] i_row_addr;
  logic [12:0] i_col_addr;
  logic [3:0]  o_Command;
  logic        o_CM_DV;
  logic [23:0] o_Addr_Data;
  logic        i_CM_Ready;
  logic [7:0]  i_RX_Feature_Byte;
  logic        i_RX_Feature_DV;
  logic [12:0] i_fifo_save_count;
  logic [2:0]  o_fifo_sm;
  logic        o_Mem_Power, o_SPI_en, o_UART_en;
  logic        o_busy, o_done, o_error;
  logic [7:0]  o_status;

  flash_page_sequencer dut (
    .CLK1(CLK1), .rst_n(rst_n), .i_start(i_start),
    .i_row_addr(i_row_addr), .i_col_addr(i_col_addr),
    .o_Command(o_Command), .o_CM_DV(o_CM_DV), .o_Addr_Data(o_Addr_Data),
    .i_CM_Ready(i_CM_Ready), .i_RX_Feature_Byte(i_RX_Feature_Byte),
    .i_RX_Feature_DV(i_RX_Feature_DV), .i_fifo_save_count(i_fifo_save_count),
    .o_fifo_sm(o_fifo_sm), .o_Mem_Power(o_Mem_Power), .o_SPI_en(o_SPI_en),
    .o_UART_en(o_UART_en), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_status(o_status)
  );

  always #5 CLK1 = ~CLK1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [3:0]  log_cmd[$];
  logic [23:0] log_addr[$];
  logic [3:0]  exp_cmd[$];
  logic [23:0] exp_addr[$];
  logic [7:0]  feat_q[$];
  bit          stuck_oip;
  int          dv_bad_ready, dv_long;
  int          resp_busy;
  bit          resp_feat;
  bit          prev_dv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mem_command stand-in: logs each command, goes busy for a random time,
  // returns a feature byte for GET_FEATURE, then reports ready again.
  initial begin
    i_CM_Ready = 1'b1; i_RX_Feature_DV = 1'b0; i_RX_Feature_Byte = 8'h00;
    resp_busy = 0; resp_feat = 1'b0; prev_dv = 1'b0;
    forever begin
      @(negedge CLK1);
      if (!rst_n) begin
        i_CM_Ready = 1'b1; i_RX_Feature_DV = 1'b0; resp_busy = 0; prev_dv = 1'b0;
        continue;
      end
      if (o_CM_DV) begin
        log_cmd.push_back(o_Command);
        log_addr.push_back(o_Addr_Data);
        if (!i_CM_Ready) dv_bad_ready++;
        if (prev_dv) dv_long++;
      end
      prev_dv = o_CM_DV;
      if (i_RX_Feature_DV) begin
        i_RX_Feature_DV = 1'b0;
        i_CM_Ready = 1'b1;
      end else if (resp_busy > 0) begin
        resp_busy--;
        if (resp_busy == 0) begin
          if (resp_feat) begin
            if (stuck_oip) i_RX_Feature_Byte = 8'h01;
            else if (feat_q.size() > 0) i_RX_Feature_Byte = feat_q.pop_front();
            else i_RX_Feature_Byte = 8'h00;
            i_RX_Feature_DV = 1'b1;
          end else begin
            i_CM_Ready = 1'b1;
          end
        end
      end else if (o_CM_DV) begin
        i_CM_Ready = 1'b0;
        resp_busy = $urandom_range(1, 4);
        resp_feat = (o_Command == GET_FEATURE);
      end
    end
  end

  // FIFO occupancy: fills toward a page or drains toward empty, per mode.
  initial begin
    forever begin
      @(negedge CLK1);
      if (rst_n) begin
        int c;
        int s;
        c = int'(i_fifo_save_count);
        s = $urandom_range(64, 512);
        case (o_fifo_sm)
          FIFO_UART_RECEIVE, FIFO_MEM_RECEIVE: c = (c + s > 2048) ? 2048 : c + s;
          FIFO_MEM_SEND, FIFO_UART_SEND:       c = (c > s) ? c - s : 0;
          default: ;
        endcase
        i_fifo_save_count = 13'(c);
      end
    end
  end

  function automatic int count_gf();
    int n = 0;
    foreach (log_cmd[i]) if (log_cmd[i] == GET_FEATURE) n++;
    return n;
  endfunction

  task automatic push_exp(input logic [3:0] c, input logic [23:0] a);
    exp_cmd.push_back(c);
    exp_addr.push_back(a);
  endtask

  // Expected command list for one round trip, from the page-flow rules.
  task automatic model_seq(input logic [23:0] row, input logic [12:0] col,
                           input int polls1, input int polls2, input bit fail1);
    exp_cmd.delete(); exp_addr.delete();
    push_exp(WRITE_ENABLE, 24'h0);
    push_exp(PROG_LOAD1, {11'b0, col});
    push_exp(PROG_EXEC, row);
    repeat (polls1) push_exp(GET_FEATURE, GF_ADDR);
    if (!fail1) begin
      push_exp(PAGE_READ, row);
      repeat (polls2) push_exp(GET_FEATURE, GF_ADDR);
      push_exp(CACHE_READ, {11'b0, col});
    end
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_log_len"}, 32'(log_cmd.size()), 32'(exp_cmd.size()));
    foreach (exp_cmd[i]) begin
      if (i < log_cmd.size()) begin
        check($sformatf("%s_cmd[%0d]", tag, i), 32'(log_cmd[i]), 32'(exp_cmd[i]));
        if (exp_cmd[i] != WRITE_ENABLE)
          check($sformatf("%s_addr[%0d]", tag, i), 32'(log_addr[i]), 32'(exp_addr[i]));
      end
    end
    check({tag, "_dv_only_when_ready"}, 32'(dv_bad_ready), 0);
    check({tag, "_dv_single_cycle"}, 32'(dv_long), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; i_start = 1'b0; i_fifo_save_count = 13'd0;
    stuck_oip = 1'b0; feat_q.delete();
    repeat (3) @(negedge CLK1);
    rst_n = 1'b1;
    @(negedge CLK1);
  endtask

  // Pulse i_start and count clock edges until the UART is enabled (end of PWR_UP).
  task automatic start_and_measure(output int cyc);
    @(negedge CLK1); i_start = 1'b1;
    @(negedge CLK1); i_start = 1'b0;
    cyc = 0;
    while (!o_UART_en && cyc < 3000) begin
      @(posedge CLK1); #1;
      cyc++;
    end
  endtask

  task automatic wait_for(input int sel, input int max, output bit hit, output int cyc);
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < max) begin
      @(posedge CLK1); #1;
      cyc++;
      case (sel)
        0:       hit = o_done;
        1:       hit = o_error;
        2:       hit = (o_fifo_sm == FIFO_MEM_SEND);
        default: hit = (count_gf() > 300);
      endcase
    end
  endtask

  task automatic run_page(input string tag, input logic [23:0] row, input logic [12:0] col,
                          input int n1, input int n2, input logic [7:0] oip_mask,
                          input logic [7:0] last1, input logic [7:0] last2, input bit second_start);
    int cyc;
    bit hit;
    feat_q.delete();
    repeat (n1) feat_q.push_back(8'h01 | (8'($urandom) & oip_mask));
    feat_q.push_back(last1);
    repeat (n2) feat_q.push_back(8'h01 | (8'($urandom) & oip_mask));
    feat_q.push_back(last2);
    i_row_addr = row; i_col_addr = col;
    log_cmd.delete(); log_addr.delete(); dv_bad_ready = 0; dv_long = 0;
    model_seq(row, col, n1 + 1, n2 + 1, 1'b0);
    start_and_measure(cyc);
    check({tag, "_pwr_up_cycles"}, 32'(cyc), 1000);
    check({tag, "_busy"}, 32'(o_busy), 1);
    check({tag, "_error_cleared"}, 32'(o_error), 0);
    check({tag, "_mem_power"}, 32'(o_Mem_Power), 1);
    if (second_start) begin
      @(negedge CLK1); i_start = 1'b1;
      @(negedge CLK1); i_start = 1'b0;
      check({tag, "_uart_en_after_2nd_start"}, 32'(o_UART_en), 1);
    end
    wait_for(0, 6000, hit, cyc);
    check({tag, "_done_seen"}, 32'(hit), 1);
    if (second_start) check({tag, "_no_restart"}, 32'(cyc < 1000), 1);
    check({tag, "_status"}, 32'(o_status), 32'(last2));
    @(posedge CLK1); #1;
    check({tag, "_done_width"}, 32'(o_done), 0);
    check({tag, "_busy_after_done"}, 32'(o_busy), 0);
    compare_log(tag);
  endtask

  initial begin
    int  cyc;
    bit  hit;
    logic [23:0] row;
    logic [12:0] col;
    rst_n = 1'b1; i_start = 1'b0; i_row_addr = 24'h0; i_col_addr = 13'h0;
    i_fifo_save_count = 13'd0; stuck_oip = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("reset_command", 32'(o_Command), 32'(NO_COMMAND));
    check("reset_fifo_sm", 32'(o_fifo_sm), 32'(FIFO_IDLE));
    check("reset_flags", 32'({o_CM_DV, o_Mem_Power, o_SPI_en, o_UART_en, o_busy, o_done, o_error}), 0);
    check("reset_addr_status", 32'({o_Addr_Data, o_status}), 0);
    apply_reset();

    // Directed page: two polls after program, a stray start during URX.
    run_page("directed", 24'h000040, 13'h0034, 1, 0, 8'h00, 8'h00, 8'h00, 1'b1);

    // Randomized pages with random OIP-busy poll counts and feature bytes.
    for (int r = 0; r < 3; r++) begin
      row = 24'($urandom);
      col = 13'($urandom_range(0, 8191));
      run_page($sformatf("rand%0d", r), row, col, $urandom_range(0, 3), $urandom_range(0, 3),
               8'hFE, 8'($urandom) & 8'hF6, 8'($urandom) & 8'hFE, 1'b0);
    end

    // Program failure reported in the first poll.
    feat_q.delete(); feat_q.push_back(8'h08);
    row = 24'h00ABCD; col = 13'h0100;
    i_row_addr = row; i_col_addr = col;
    log_cmd.delete(); log_addr.delete(); dv_bad_ready = 0; dv_long = 0;
    model_seq(row, col, 1, 0, 1'b1);
    start_and_measure(cyc);
    check("pfail_pwr_up_cycles", 32'(cyc), 1000);
    wait_for(1, 6000, hit, cyc);
    check("pfail_error_seen", 32'(hit), 1);
    repeat (3) @(posedge CLK1);
    #1;
    check("pfail_error_sticky", 32'(o_error), 1);
    check("pfail_status", 32'(o_status), 32'h08);
    check("pfail_busy", 32'(o_busy), 0);
    check("pfail_mem_power", 32'(o_Mem_Power), 1);
    compare_log("pfail");

    // Restart straight out of the error state.
    run_page("restart", 24'h123456, 13'h1FFF, 0, 1, 8'h00, 8'h00, 8'h20, 1'b0);

    // Asynchronous reset while the page is being loaded.
    log_cmd.delete(); log_addr.delete();
    start_and_measure(cyc);
    wait_for(2, 3000, hit, cyc);
    check("midload_reached_load", 32'(hit), 1);
    @(negedge CLK1);
    check("midload_power_before", 32'(o_Mem_Power), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midload_power_dropped", 32'(o_Mem_Power), 0);
    check("midload_fifo_sm", 32'(o_fifo_sm), 32'(FIFO_IDLE));
    check("midload_command", 32'(o_Command), 32'(NO_COMMAND));
    check("midload_flags", 32'({o_CM_DV, o_SPI_en, o_UART_en, o_busy, o_done, o_error}), 0);
    check("midload_addr_status", 32'({o_Addr_Data, o_status}), 0);
    apply_reset();

    // OIP stuck high after program.
    stuck_oip = 1'b1;
    log_cmd.delete(); log_addr.delete();
    start_and_measure(cyc);
`ifdef SEQ_POLL_TIMEOUT_EN
    wait_for(1, 8000, hit, cyc);
    check("timeout_error_seen", 32'(hit), 1);
    check("timeout_gf_count", 32'(count_gf()), 255);
    check("timeout_status", 32'(o_status), 32'h01);
    check("timeout_busy", 32'(o_busy), 0);
`else
    wait_for(3, 8000, hit, cyc);
    check("unbounded_polls_past_300", 32'(hit), 1);
    check("unbounded_no_error", 32'(o_error), 0);
    check("unbounded_busy", 32'(o_busy), 1);
`endif
    apply_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/flash_page_sequencer.md
Name: flash_page_sequencer

Overview:
- Top-level scheduler that sequences one full page round-trip through mem_command: UART page receive → SPI-NAND program → read-back → UART page send.
- Drives command, DV and address to mem_command; drives the shared FIFO mode (i_fifo_sm); owns memory power and the SPI/UART enables.
- Replaces ad-hoc sequencing in top.

Parameters:
- PAGE_BYTES, 2048, bytes per page transfer; FIFO fill threshold.
- POWER_UP_CYCLES, 1000, CLK1 cycles from power-on to first command.
- MAX_POLLS, 255, GET_FEATURE polls allowed before error.
- FEATURE_ADDR, 8'hC0, status feature register address.

Ports:
- CLK1  in  1  clock.
- rst_n  in  1  async active-low reset.
- i_start  in  1  one-cycle start pulse (debounced pb_sw1).
- i_row_addr  in  24  page row address.
- i_col_addr  in  13  column start address.
- o_Command  out  SPI_Command  to mem_command i_Command.
- o_CM_DV  out  1  command valid pulse.
- o_Addr_Data  out  24  command address/data.
- i_CM_Ready  in  1  mem_command ready.
- i_RX_Feature_Byte  in  8  returned feature byte.
- i_RX_Feature_DV  in  1  feature byte valid.
- i_fifo_save_count  in  13  FIFO occupancy.
- o_fifo_sm  out  3  FIFO mode (FIFO_* encodings from command_vars.v).
- o_Mem_Power, o_SPI_en, o_UART_en  out  1 each  resource control.
- o_busy  out  1  sequence in progress.
- o_done  out  1  one-cycle completion pulse.
- o_error  out  1  sticky error flag.
- o_status  out  8  last feature byte.

Behaviour:
- Reset: all outputs 0; o_Command=NO_COMMAND; o_fifo_sm=FIFO_IDLE; state IDLE.
- Command handshake, states marked (c):
  - Wait for i_CM_Ready=1, then drive o_Command/o_Addr_Data and pulse o_CM_DV for exactly 1 cycle.
  - Wait for i_CM_Ready=0 (accepted), then i_CM_Ready=1 (complete), then advance.
  - o_Addr_Data holds until the next command.
- Address packing:
  - PROG_LOAD1/CACHE_READ: {11'b0, col}.
  - PROG_EXEC/PAGE_READ: row.
  - GET_FEATURE: [15:8]=FEATURE_ADDR, rest 0.
- States:
  - IDLE: i_start → PWR_UP; set o_busy, clear o_error.
  - PWR_UP: o_Mem_Power=1, o_SPI_en=1; counter to POWER_UP_CYCLES-1 → URX.
  - URX: o_UART_en=1, o_fifo_sm=FIFO_UART_RECEIVE; i_fifo_save_count>=PAGE_BYTES → WREN.
  - WREN (c) WRITE_ENABLE → LOAD.
  - LOAD (c) PROG_LOAD1; o_fifo_sm=FIFO_MEM_SEND; complete and count==0 → EXEC.
  - EXEC (c) PROG_EXEC → POLL1.
  - POLL1/POLL2 (c) GET_FEATURE:
    - Capture i_RX_Feature_Byte into o_status on i_RX_Feature_DV.
    - Bit0 (OIP)=1 → reissue.
    - Bit3 (P_FAIL)=1 in POLL1 → ERR.
    - Else POLL1 → RDPG, POLL2 → CRD.
  - RDPG (c) PAGE_READ → POLL2.
  - CRD (c) CACHE_READ; o_fifo_sm=FIFO_MEM_RECEIVE; count>=PAGE_BYTES → UTX.
  - UTX: o_fifo_sm=FIFO_UART_SEND; count==0 → DONE.
  - DONE: o_done=1 one cycle; o_busy=0; o_fifo_sm=FIFO_IDLE → IDLE.
  - ERR: o_error=1 sticky; o_busy=0; o_Mem_Power stays 1; i_start restarts from PWR_UP.
- i_start while busy: ignored.
- i_RX_Feature_DV outside POLL states: ignored.
- Poll counter: 8-bit; reset on poll-state entry; saturates, no wrap.
- rst_n mid-sequence: immediate return to reset values; memory power drops the same cycle.

Optional Feature:
- Macro SEQ_POLL_TIMEOUT_EN.
- Defined: poll count reaching MAX_POLLS with OIP still 1 → ERR, o_status holds last byte.
- Undefined: unbounded polling, counter logic absent.

Test Plan:
- Reset with rst_n=0 mid-LOAD → all outputs 0, o_fifo_sm=FIFO_IDLE, o_Mem_Power=0 same cycle.
- i_start, ready model, count ramps to 2048, features 8'h01 then 8'h00 → command order WRITE_ENABLE, PROG_LOAD1 (addr 0x34), PROG_EXEC (row 0x000040), GET_FEATURE ×2, PAGE_READ, GET_FEATURE, CACHE_READ, then o_done pulse.
- Pulse count check → each o_CM_DV exactly 1 cycle high, only when i_CM_Ready=1; PWR_UP lasts exactly 1000 cycles.
- POLL1 returns 8'h08 → ERR, o_error=1, o_status=8'h08, no PAGE_READ issued.
- SEQ_POLL_TIMEOUT_EN defined, OIP stuck at 1 → ERR after 255 GET_FEATUREs; undefined → polling continues past 300.
- Second i_start during URX → no effect; i_start after ERR → sequence restarts at PWR_UP.
